// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: icodes, ALU/condition function codes,
// the "no register" ID and the condition-code bundle.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] RNONE = 4'hF;

    typedef enum logic [3:0] {
        A_ADD = 4'h0,
        A_SUB = 4'h1,
        A_AND = 4'h2,
        A_XOR = 4'h3,
        A_MUL = 4'h4
    } alu_fn_e;

    typedef enum logic [3:0] {
        C_YES = 4'h0,
        C_LE  = 4'h1,
        C_L   = 4'h2,
        C_E   = 4'h3,
        C_NE  = 4'h4,
        C_GE  = 4'h5,
        C_G   = 4'h6
    } cond_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
    } cc_t;

    function automatic logic cond_eval(
        input cc_t        cc,
        input logic [3:0] fn
    );
        logic lt;
        logic r;
        lt = cc.sf ^ cc.of;
        case (fn)
            C_YES:   r = 1'b1;
            C_LE:    r = lt | cc.zf;
            C_L:     r = lt;
            C_E:     r = cc.zf;
            C_NE:    r = !cc.zf;
            C_GE:    r = !lt;
            C_G:     r = !lt & !cc.zf;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational OPq ALU: add/sub/and/xor on valB op valA with flags.
// o_ok is low for function codes this ALU does not implement.
module exec_alu
    import y86_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [3:0]      i_fn,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_res,
    output cc_t             o_cc,
    output logic            o_ok
);

    localparam int MSB = XLEN - 1;

    logic w_of;

    always_comb begin
        o_res = '0;
        o_ok  = 1'b1;
        w_of  = 1'b0;
        case (i_fn)
            A_ADD: begin
                o_res = i_b + i_a;
                w_of  = (i_a[MSB] == i_b[MSB]) &&
                        (o_res[MSB] != i_b[MSB]);
            end
            A_SUB: begin
                o_res = i_b - i_a;
                w_of  = (i_a[MSB] != i_b[MSB]) &&
                        (o_res[MSB] != i_b[MSB]);
            end
            A_AND:   o_res = i_b & i_a;
            A_XOR:   o_res = i_b ^ i_a;
            default: o_ok = 1'b0;
        endcase
        o_cc.zf = (o_res == '0);
        o_cc.sf = o_res[MSB];
        o_cc.of = w_of;
    end

endmodule

// File: rtl/exec_stage.sv
// Y86-64 execute stage: valE, cmov/jxx condition, CC register, output
// handshake register. Define EXEC_MUL_EN for the multi-cycle mulq FSM.
module exec_stage
    import y86_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_icode,
    input  logic [3:0]      in_ifun,
    input  logic [XLEN-1:0] in_valA,
    input  logic [XLEN-1:0] in_valB,
    input  logic [XLEN-1:0] in_valC,
    input  logic [3:0]      in_dstE,
    input  logic [3:0]      in_dstM,
    input  logic            cc_hold,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_icode,
    output logic            out_cnd,
    output logic [XLEN-1:0] out_valE,
    output logic [XLEN-1:0] out_valA,
    output logic [3:0]      out_dstE,
    output logic [3:0]      out_dstM,
    output logic            cc_zf,
    output logic            cc_sf,
    output logic            cc_of
);

    localparam logic [XLEN-1:0] EIGHT = XLEN'(8);

    cc_t             r_cc;
    logic            busy;
    logic            w_acc;
    logic            w_out_free;
    logic            w_is_mul;
    logic [XLEN-1:0] w_alu_res;
    cc_t             w_alu_cc;
    logic            w_alu_ok;
    logic [XLEN-1:0] w_valE;
    logic            w_cnd;
    logic [3:0]      w_dstE;
    logic            w_cc_wr;
    logic            w_mul_load;
    logic [XLEN-1:0] w_mul_res;
    logic [XLEN-1:0] w_m_valA;
    logic [3:0]      w_m_dstE;
    logic [3:0]      w_m_dstM;

    assign w_out_free = !out_valid | out_ready;
    assign in_ready   = !busy & w_out_free;
    assign w_acc      = in_valid & in_ready & !flush;

    assign cc_zf = r_cc.zf;
    assign cc_sf = r_cc.sf;
    assign cc_of = r_cc.of;

    exec_alu #(.XLEN(XLEN)) u_alu (
        .i_fn  (in_ifun),
        .i_a   (in_valA),
        .i_b   (in_valB),
        .o_res (w_alu_res),
        .o_cc  (w_alu_cc),
        .o_ok  (w_alu_ok)
    );

    always_comb begin
        w_valE = '0;
        case (in_icode)
            I_RRMOVQ: w_valE = in_valA;
            I_IRMOVQ: w_valE = in_valC;
            I_RMMOVQ,
            I_MRMOVQ: w_valE = in_valB + in_valC;
            I_CALL,
            I_PUSHQ:  w_valE = in_valB - EIGHT;
            I_RET,
            I_POPQ:   w_valE = in_valB + EIGHT;
            I_OPQ:    w_valE = w_alu_ok ? w_alu_res : '0;
            default:  w_valE = '0;
        endcase
    end

    // Conditions see the CC as it stood before this instruction.
    always_comb begin
        w_cnd = 1'b1;
        if (in_icode == I_RRMOVQ || in_icode == I_JXX)
            w_cnd = cond_eval(r_cc, in_ifun);
        w_dstE = (in_icode == I_RRMOVQ && !w_cnd) ? RNONE : in_dstE;
    end

    assign w_cc_wr = w_acc & (in_icode == I_OPQ) & w_alu_ok & !cc_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cc <= '{zf: 1'b1, sf: 1'b0, of: 1'b0};
        end else if (w_cc_wr) begin
            r_cc <= w_alu_cc;
        end else if (w_mul_load & !cc_hold) begin
            r_cc <= '{zf: (w_mul_res == '0),
                      sf: w_mul_res[XLEN-1],
                      of: 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_icode <= '0;
            out_cnd   <= 1'b0;
            out_valE  <= '0;
            out_valA  <= '0;
            out_dstE  <= RNONE;
            out_dstM  <= RNONE;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (w_mul_load) begin
            out_valid <= 1'b1;
            out_icode <= I_OPQ;
            out_cnd   <= 1'b1;
            out_valE  <= w_mul_res;
            out_valA  <= w_m_valA;
            out_dstE  <= w_m_dstE;
            out_dstM  <= w_m_dstM;
        end else if (w_acc & !w_is_mul) begin
            out_valid <= 1'b1;
            out_icode <= in_icode;
            out_cnd   <= w_cnd;
            out_valE  <= w_valE;
            out_valA  <= in_valA;
            out_dstE  <= w_dstE;
            out_dstM  <= in_dstM;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef EXEC_MUL_EN

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } mul_state_e;

    localparam int CW = $clog2(XLEN);

    mul_state_e      r_state;
    mul_state_e      w_next;
    logic [XLEN-1:0] r_mcand;
    logic [XLEN-1:0] r_mplier;
    logic [XLEN-1:0] r_prod;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_m_valA;
    logic [3:0]      r_m_dstE;
    logic [3:0]      r_m_dstM;
    logic [XLEN-1:0] w_step;
    logic            w_last;

    assign w_is_mul = (in_icode == I_OPQ) && (in_ifun == A_MUL);
    assign busy     = (r_state != S_IDLE);
    assign w_step   = r_prod + (r_mplier[0] ? r_mcand : '0);
    assign w_last   = (r_cnt == CW'(XLEN - 1));
    assign w_m_valA = r_m_valA;
    assign w_m_dstE = r_m_dstE;
    assign w_m_dstM = r_m_dstM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_mul_load = 1'b0;
        w_mul_res  = r_prod;
        case (r_state)
            S_IDLE: begin
                if (w_acc & w_is_mul) w_next = S_MUL;
            end
            S_MUL: begin
                if (w_last) begin
                    w_mul_res = w_step;
                    if (w_out_free) begin
                        w_mul_load = 1'b1;
                        w_next     = S_IDLE;
                    end else begin
                        w_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (w_out_free) begin
                    w_mul_load = 1'b1;
                    w_next     = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (flush) begin
            w_mul_load = 1'b0;
            w_next     = S_IDLE;
        end
    end

    // Shift-add: one multiplier bit per cycle, LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_m_valA <= '0;
            r_m_dstE <= RNONE;
            r_m_dstM <= RNONE;
        end else if (w_acc & w_is_mul) begin
            r_mcand  <= in_valB;
            r_mplier <= in_valA;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_m_valA <= in_valA;
            r_m_dstE <= in_dstE;
            r_m_dstM <= in_dstM;
        end else if (r_state == S_MUL) begin
            r_prod   <= w_step;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
        end
    end

`else

    assign w_is_mul   = 1'b0;
    assign busy       = 1'b0;
    assign w_mul_load = 1'b0;
    assign w_mul_res  = '0;
    assign w_m_valA   = '0;
    assign w_m_dstE   = RNONE;
    assign w_m_dstM   = RNONE;

`endif

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: directed plan items plus random
// traffic against a flag/arithmetic reference model.
module tb_exec_stage;

    localparam int XLEN = 64;
    typedef logic [XLEN-1:0] word_t;
    localparam word_t W_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam word_t W_MAX  = {1'b0, {(XLEN-1){1'b1}}};
    localparam word_t W_ONES = {XLEN{1'b1}};

    typedef struct {
        logic [3:0] icode;
        logic       cnd;
        word_t      valE;
        word_t      valA;
        logic [3:0] dstE;
        logic [3:0] dstM;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_icode, in_ifun;
    word_t      in_valA, in_valB, in_valC;
    logic [3:0] in_dstE, in_dstM;
    logic       cc_hold, flush;
    logic       out_valid, out_ready;
    logic [3:0] out_icode;
    logic       out_cnd;
    word_t      out_valE, out_valA;
    logic [3:0] out_dstE, out_dstM;
    logic       cc_zf, cc_sf, cc_of;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_xfer = 0;
    logic m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0;
    bit   cc_chk_en = 0;
    bit   last_acc  = 0;

    exec_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valA(in_valA), .in_valB(in_valB), .in_valC(in_valC),
        .in_dstE(in_dstE), .in_dstM(in_dstM),
        .cc_hold(cc_hold), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_icode(out_icode), .out_cnd(out_cnd),
        .out_valE(out_valE), .out_valA(out_valA),
        .out_dstE(out_dstE), .out_dstM(out_dstM),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input word_t act, input word_t req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    function automatic logic cond_ok(input logic [3:0] fn,
                                     input logic zf, sf, of);
        logic less;
        less = (sf != of);
        case (fn)
            4'd0:    return 1'b1;
            4'd1:    return less || zf;
            4'd2:    return less;
            4'd3:    return zf;
            4'd4:    return !zf;
            4'd5:    return !less;
            4'd6:    return !less && !zf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit is_mulq(input logic [3:0] ic, fn);
`ifdef EXEC_MUL_EN
        return (ic == 4'h6) && (fn == 4'h4);
`else
        return 1'b0;
`endif
    endfunction

    // Reference: computes expected output and, for OPq, the new flags.
    task automatic ref_model(output exp_t e);
        logic signed [XLEN:0] wide;
        word_t a, b, r;
        bit   wr, ovf;
        a = in_valA; b = in_valB;
        r = '0; wr = 0; ovf = 0;
        e.icode = in_icode;
        e.valA  = in_valA;
        e.dstM  = in_dstM;
        e.dstE  = in_dstE;
        e.cnd   = 1'b1;
        case (in_icode)
            4'h2: begin
                r = a;
                e.cnd = cond_ok(in_ifun, m_zf, m_sf, m_of);
                if (!e.cnd) e.dstE = 4'hF;
            end
            4'h7: e.cnd = cond_ok(in_ifun, m_zf, m_sf, m_of);
            4'h3: r = in_valC;
            4'h4, 4'h5: r = b + in_valC;
            4'h8, 4'hA: r = b - 8;
            4'h9, 4'hB: r = b + 8;
            4'h6: begin
                if (in_ifun == 4'd0 || in_ifun == 4'd1) begin
                    if (in_ifun == 4'd0)
                        wide = $signed({b[XLEN-1], b}) + $signed({a[XLEN-1], a});
                    else
                        wide = $signed({b[XLEN-1], b}) - $signed({a[XLEN-1], a});
                    r = wide[XLEN-1:0];
                    ovf = (wide > $signed({2'b00, {(XLEN-1){1'b1}}})) ||
                          (wide < $signed({2'b11, {(XLEN-1){1'b0}}}));
                    wr = 1;
                end else if (in_ifun == 4'd2) begin
                    r = b & a; wr = 1;
                end else if (in_ifun == 4'd3) begin
                    r = b ^ a; wr = 1;
                end else if (is_mulq(in_icode, in_ifun)) begin
                    r = b * a;
                end
            end
            default: r = '0;
        endcase
        e.valE = r;
        if (wr && !cc_hold) begin
            m_zf = (r == '0);
            m_sf = r[XLEN-1];
            m_of = ovf;
        end
    endtask

    // One clock: check flags, record accept/flush, advance to posedge+1.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (cc_chk_en)
            chk("cc", {cc_zf, cc_sf, cc_of}, {m_zf, m_sf, m_of});
        last_acc = in_valid && in_ready && !flush;
        if (flush) sb.delete();
        if (last_acc) begin
            ref_model(e);
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [3:0] ic, fn,
                         input word_t a, b, c,
                         input logic [3:0] de, dm);
        in_icode = ic; in_ifun = fn;
        in_valA = a; in_valB = b; in_valC = c;
        in_dstE = de; in_dstM = dm;
        in_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            cycle();
            if (last_acc) break;
        end
        in_valid = 1'b0;
        chk("issue_accept", word_t'(last_acc), word_t'(1));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready && !flush) begin
            n_xfer++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL xfer: unexpected output valE=%h", out_valE);
            end else begin
                e = sb.pop_front();
                if (out_icode !== e.icode || out_cnd !== e.cnd ||
                    out_valE !== e.valE || out_valA !== e.valA ||
                    out_dstE !== e.dstE || out_dstM !== e.dstM) begin
                    errors++;
                    $display("FAIL xfer: got ic=%h cnd=%b valE=%h valA=%h dE=%h dM=%h required ic=%h cnd=%b valE=%h valA=%h dE=%h dM=%h",
                             out_icode, out_cnd, out_valE, out_valA,
                             out_dstE, out_dstM, e.icode, e.cnd, e.valE,
                             e.valA, e.dstE, e.dstM);
                end
            end
        end
    end

    function automatic word_t rnd_word();
        case ($urandom % 7)
            0:       return '0;
            1:       return W_ONES;
            2:       return W_MIN;
            3:       return W_MAX;
            4:       return word_t'($urandom_range(0, 16));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n0;
        int lat;
        logic [3:0] ic, fn;
        rst_n = 1'b0;
        in_valid = 0; in_icode = 0; in_ifun = 0;
        in_valA = 0; in_valB = 0; in_valC = 0;
        in_dstE = 0; in_dstM = 0;
        cc_hold = 0; flush = 0; out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", word_t'(out_valid), 0);
        chk("rst_valE", out_valE, 0);
        chk("rst_valA", out_valA, 0);
        chk("rst_icode", word_t'(out_icode), 0);
        chk("rst_dstE", word_t'(out_dstE), word_t'(4'hF));
        chk("rst_dstM", word_t'(out_dstM), word_t'(4'hF));
        chk("rst_cc", word_t'({cc_zf, cc_sf, cc_of}), word_t'(3'b100));
        chk("rst_in_ready", word_t'(in_ready), 1);
        rst_n = 1'b1;
        cc_chk_en = 1;

        issue(4'h6, 4'h0, 1, W_ONES, 0, 4'h3, 4'hF);
        issue(4'h6, 4'h1, 1, W_MIN, 0, 4'h3, 4'hF);
        issue(4'h7, 4'h2, 0, 0, 0, 4'hF, 4'hF);
        issue(4'h6, 4'h0, 1, W_ONES, 0, 4'h3, 4'hF);
        issue(4'h2, 4'h4, 64'h1234, 0, 0, 4'h5, 4'hF);
        cycle();
        cycle();

        // Back-pressure: pushq result must hold while out_ready is low.
        out_ready = 1'b0;
        issue(4'hA, 4'h0, 0, 64'h100, 0, 4'h4, 4'hF);
        for (int k = 0; k < 3; k++) begin
            chk("hold_valid", word_t'(out_valid), 1);
            chk("hold_valE", out_valE, 64'hF8);
            chk("hold_in_ready", word_t'(in_ready), 0);
            cycle();
        end
        n0 = n_xfer;
        out_ready = 1'b1;
        cycle();
        chk("one_xfer", word_t'(n_xfer - n0), 1);
        chk("drained", word_t'(out_valid), 0);

        cc_hold = 1'b1;
        issue(4'h6, 4'h0, 5, 5, 0, 4'h1, 4'hF);
        cc_hold = 1'b0;
        cycle();
        cycle();

        // Flush in the same cycle as in_valid: nothing accepted.
        in_icode = 4'h6; in_ifun = 4'h3;
        in_valA = 7; in_valB = 9;
        in_valid = 1'b1; flush = 1'b1;
        cycle();
        in_valid = 1'b0; flush = 1'b0;
        chk("flush_same_cycle", word_t'(out_valid), 0);
        cycle();

`ifdef EXEC_MUL_EN
        issue(4'h6, 4'h4, -64'sd3, 7, 0, 4'h2, 4'hF);
        cc_chk_en = 0;
        chk("mul_ready0", word_t'(in_ready), 0);
        lat = -1;
        for (int k = 1; k <= XLEN + 4; k++) begin
            cycle();
            if (out_valid) begin
                lat = k;
                break;
            end
            chk("mul_ready", word_t'(in_ready), 0);
        end
        chk("mul_latency", word_t'(lat), word_t'(XLEN));
        m_zf = 1'b0; m_sf = 1'b1; m_of = 1'b0;
        cycle();
        cc_chk_en = 1;
        cycle();

        issue(4'h6, 4'h4, 3, 2, 0, 4'h2, 4'hF);
        repeat (9) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("mul_abort_valid", word_t'(out_valid), 0);
        chk("mul_abort_ready", word_t'(in_ready), 1);
        repeat (XLEN + 2) cycle();
        chk("mul_abort_quiet", word_t'(out_valid), 0);
`endif

        for (int n = 0; n < 400; n++) begin
            ic = 4'($urandom_range(0, 15));
            if (ic == 4'h2 || ic == 4'h6 || ic == 4'h7)
                fn = 4'($urandom_range(0, 8));
            else
                fn = 4'($urandom_range(0, 15));
            if (is_mulq(ic, fn)) fn = 4'h5;
            in_icode = ic; in_ifun = fn;
            in_valA = rnd_word(); in_valB = rnd_word();
            in_valC = rnd_word();
            in_dstE = 4'($urandom_range(0, 15));
            in_dstM = 4'($urandom_range(0, 15));
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 10) < 7;
            cc_hold   = ($urandom % 8) == 0;
            cycle();
        end
        in_valid = 0; cc_hold = 0; out_ready = 1;
        repeat (4) cycle();
        chk("sb_empty", word_t'(sb.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
